// File: rtl/pulse_width_decoder.sv
// Purpose : measures active-low pulses on cf_in and decodes legal lengths k*tvalue-1
//           (k = 1,2,4,8) into a 2-bit multiplier code; other lengths or a stuck-low strobe raise err.
// Latency : the report (valid or err) appears one cycle after the high sample that ends the pulse.
//           A stuck-low err appears one cycle after the 8*tvalue-th low sample.
// Backpressure: none; cf_in is sampled every cycle and each report is a one-cycle pulse.
// Ports   : clk, reset (async, active-high), cf_in (strobe, active low),
//           multiplier (last decoded code), valid / err (one-cycle report pulses),
//           low_len (length of the last completed or aborted pulse),
//           busy (a pulse is being measured or drained).
module pulse_width_decoder #(
    parameter int unsigned tvalue = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cf_in,
    output logic [1:0]  multiplier,
    output logic        valid,
    output logic        err,
    output logic [31:0] low_len,
    output logic        busy
);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        MEASURE   = 2'd2,
        STUCK     = 2'd3
    } state_t;

    // Legal pulse lengths. tvalue <= 2^28 keeps 8*tvalue inside 32 bits.
    localparam logic [31:0] T_VAL = 32'(tvalue);
    localparam logic [31:0] L1    = T_VAL - 32'd1;
    localparam logic [31:0] L2    = (T_VAL << 1) - 32'd1;
    localparam logic [31:0] L4    = (T_VAL << 2) - 32'd1;
    localparam logic [31:0] L8    = (T_VAL << 3) - 32'd1;
    // A pulse reaching this many low samples can no longer be legal.
    localparam logic [31:0] L_MAX = T_VAL << 3;

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [1:0]  multiplier_q, multiplier_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] low_len_q, low_len_d;
    logic        busy_q, busy_d;
    logic [31:0] count_inc;

    assign count_inc = count_q + 32'd1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_HIGH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            // Out of reset the strobe may already be low; wait for high so a
            // partial pulse is never measured.
            WAIT_HIGH: if (cf_in) state_d = IDLE;
            IDLE:      if (!cf_in) state_d = MEASURE;
            MEASURE: begin
                if (cf_in) begin
                    state_d = IDLE;
                end else if (count_inc == L_MAX) begin
                    state_d = STUCK;
                end
            end
            STUCK:     if (cf_in) state_d = IDLE;
            default:   state_d = WAIT_HIGH;
        endcase
    end

    // Output / datapath logic, registered below
    always_comb begin
        count_d      = count_q;
        multiplier_d = multiplier_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        low_len_d    = low_len_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (!cf_in) begin
                    count_d = 32'd1;
                    busy_d  = 1'b1;
                end
            end
            MEASURE: begin
                if (cf_in) begin
                    low_len_d = count_q;
                    busy_d    = 1'b0;
                    if (count_q == L1) begin
                        valid_d      = 1'b1;
                        multiplier_d = 2'b00;
                    end else if (count_q == L2) begin
                        valid_d      = 1'b1;
                        multiplier_d = 2'b01;
                    end else if (count_q == L4) begin
                        valid_d      = 1'b1;
                        multiplier_d = 2'b10;
                    end else if (count_q == L8) begin
                        valid_d      = 1'b1;
                        multiplier_d = 2'b11;
                    end else begin
                        // Illegal length: multiplier keeps the last good code.
                        err_d = 1'b1;
                    end
                end else if (count_inc == L_MAX) begin
                    // Report the stuck strobe now rather than at release; busy
                    // stays high while the pulse drains in STUCK.
                    err_d     = 1'b1;
                    low_len_d = count_inc;
                end else begin
                    count_d = count_inc;
                end
            end
            STUCK: begin
                // Release after a stuck pulse is silent.
                if (cf_in) busy_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= 32'd0;
            multiplier_q <= 2'b00;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            low_len_q    <= 32'd0;
            busy_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            multiplier_q <= multiplier_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            low_len_q    <= low_len_d;
            busy_q       <= busy_d;
        end
    end

    assign multiplier = multiplier_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign low_len    = low_len_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Purpose : directed bench for pulse_width_decoder with tvalue = 7.
// Latency : inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next edge.
// Backpressure: not applicable; the strobe is driven every cycle.
module tb_pulse_width_decoder;

    logic        clk;
    logic        reset;
    logic        cf_in;
    logic [1:0]  multiplier;
    logic        valid;
    logic        err;
    logic [31:0] low_len;
    logic        busy;

    int tests_run;
    int tests_failed;

    pulse_width_decoder #(.tvalue(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .cf_in      (cf_in),
        .multiplier (multiplier),
        .valid      (valid),
        .err        (err),
        .low_len    (low_len),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cf_in sample, let the DUT take it, and settle 1 ns past the edge.
    task automatic step(input logic v);
        cf_in = v;
        @(posedge clk);
        #1;
    endtask

    // Drive n low samples (no checking).
    task automatic drive_low(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic test_reset;
        cf_in = 1'b1;
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        tests_run++;
        if (valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || multiplier !== 2'b00 || low_len !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b err=%b busy=%b mult=%b low_len=%0d, required all 0",
                     valid, err, busy, multiplier, low_len);
        end
        reset = 1'b0;
    endtask

    // Test 1: 3 high cycles, then a 13-cycle low pulse decodes to 2x.
    task automatic test_basic_2x;
        int busy_bad;
        int rpt_bad;
        busy_bad = 0;
        rpt_bad  = 0;
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 13; i++) begin
            step(1'b0);
            if (busy !== 1'b1) busy_bad++;
            if (valid !== 1'b0 || err !== 1'b0) rpt_bad++;
        end
        tests_run++;
        if (busy_bad != 0) begin
            tests_failed++;
            $display("FAIL t1_busy_during_low: %0d low cycles had busy=0, required 0", busy_bad);
        end
        tests_run++;
        if (rpt_bad != 0) begin
            tests_failed++;
            $display("FAIL t1_early_report: %0d low cycles showed valid/err, required 0", rpt_bad);
        end
        step(1'b1);
        tests_run++;
        if (valid !== 1'b1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_report: valid=%b err=%b, required valid=1 err=0", valid, err);
        end
        tests_run++;
        if (multiplier !== 2'b01 || low_len !== 32'd13) begin
            tests_failed++;
            $display("FAIL t1_decode: mult=%b low_len=%0d, required mult=01 low_len=13", multiplier, low_len);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_busy_after: busy=%b, required 0", busy);
        end
        step(1'b1);
        tests_run++;
        if (valid !== 1'b0 || multiplier !== 2'b01 || low_len !== 32'd13) begin
            tests_failed++;
            $display("FAIL t1_hold: valid=%b mult=%b low_len=%0d, required valid=0 mult=01 low_len=13",
                     valid, multiplier, low_len);
        end
    endtask

    // Test 2: back-to-back 6 / 27 / 55 pulses separated by single high cycles.
    task automatic test_back_to_back;
        int          lens [3];
        logic [1:0]  codes [3];
        lens  = '{6, 27, 55};
        codes = '{2'b00, 2'b10, 2'b11};
        for (int p = 0; p < 3; p++) begin
            drive_low(lens[p]);
            step(1'b1);
            tests_run++;
            if (valid !== 1'b1 || err !== 1'b0 || multiplier !== codes[p] || low_len !== 32'(lens[p])) begin
                tests_failed++;
                $display("FAIL t2_pulse%0d: valid=%b err=%b mult=%b low_len=%0d, required valid=1 err=0 mult=%b low_len=%0d",
                         p, valid, err, multiplier, low_len, codes[p], lens[p]);
            end
        end
    endtask

    // Test 3: illegal length 10 flags err and keeps multiplier.
    task automatic test_bad_length;
        drive_low(10);
        step(1'b1);
        tests_run++;
        if (err !== 1'b1 || valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL t3_err: err=%b valid=%b, required err=1 valid=0", err, valid);
        end
        tests_run++;
        if (low_len !== 32'd10 || multiplier !== 2'b11) begin
            tests_failed++;
            $display("FAIL t3_hold: low_len=%0d mult=%b, required low_len=10 mult=11", low_len, multiplier);
        end
        step(1'b1);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t3_err_one_cycle: err=%b, required 0", err);
        end
    endtask

    // Test 4: low held for 60 cycles -> stuck err after the 56th sample.
    task automatic test_stuck;
        drive_low(55);
        tests_run++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4_pre_stuck: err=%b busy=%b, required err=0 busy=1", err, busy);
        end
        step(1'b0);
        tests_run++;
        if (err !== 1'b1 || valid !== 1'b0 || low_len !== 32'd56 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4_stuck_err: err=%b valid=%b low_len=%0d busy=%b, required err=1 valid=0 low_len=56 busy=1",
                     err, valid, low_len, busy);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            tests_run++;
            if (err !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL t4_drain%0d: err=%b busy=%b, required err=0 busy=1", i, err, busy);
            end
        end
        step(1'b1);
        tests_run++;
        if (err !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 || low_len !== 32'd56) begin
            tests_failed++;
            $display("FAIL t4_release: err=%b valid=%b busy=%b low_len=%0d, required err=0 valid=0 busy=0 low_len=56",
                     err, valid, busy, low_len);
        end
    endtask

    // Test 5: strobe low across reset release; the partial pulse is ignored.
    task automatic test_low_at_reset;
        int bad;
        bad   = 0;
        cf_in = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0);
            if (valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) bad++;
        end
        step(1'b1);
        if (valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL t5_partial_ignored: %0d cycles showed valid/err/busy, required 0", bad);
        end
        drive_low(13);
        step(1'b1);
        tests_run++;
        if (valid !== 1'b1 || err !== 1'b0 || multiplier !== 2'b01 || low_len !== 32'd13) begin
            tests_failed++;
            $display("FAIL t5_second_pulse: valid=%b err=%b mult=%b low_len=%0d, required valid=1 err=0 mult=01 low_len=13",
                     valid, err, multiplier, low_len);
        end
    endtask

    // Test 6: asynchronous reset mid-pulse.
    task automatic test_async_reset;
        drive_low(5);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL t6_busy_before: busy=%b, required 1", busy);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || multiplier !== 2'b00 || low_len !== 32'd0) begin
            tests_failed++;
            $display("FAIL t6_async_clear: valid=%b err=%b busy=%b mult=%b low_len=%0d, required all 0",
                     valid, err, busy, multiplier, low_len);
        end
        cf_in = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1);
        tests_run++;
        if (valid !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_no_report: valid=%b err=%b, required 0", valid, err);
        end
        drive_low(6);
        step(1'b1);
        tests_run++;
        if (valid !== 1'b1 || err !== 1'b0 || multiplier !== 2'b00 || low_len !== 32'd6) begin
            tests_failed++;
            $display("FAIL t6_after_reset: valid=%b err=%b mult=%b low_len=%0d, required valid=1 err=0 mult=00 low_len=6",
                     valid, err, multiplier, low_len);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        cf_in        = 1'b1;
        test_reset();
        test_basic_2x();
        test_back_to_back();
        test_bad_length();
        test_stuck();
        test_low_at_reset();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
